forward_hazard_unit: RTL
========================

Name: forward_hazard_unit

Overview:
- Parametrised successor to the combinational forwarding selector.
- Tracks in-flight destination registers through shadow EX/MEM/WB stages and registers the operand-forward selects at ID→EX. Muxes forwarded data into the EX operands and detects load-use hazards, asserting a one-cycle stall.
- Sits between the decode stage and the ALU operand muxes. The branch comparator consumes ex_opb, so branches see forwarded values.

Parameters:
XLEN, 16, data width of operands and results
REGW, 4, register index width
ZERO_REG, 1, 1 = register 0 hardwired zero, never forwarded

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
id_valid  in  1  valid instruction in ID
id_rs1  in  REGW  ID source 1
id_rs2  in  REGW  ID source 2
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
id_rd  in  REGW  ID destination
id_regwrite  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load
flush  in  1  squash the instruction entering EX (branch taken)
ex_opa_in  in  XLEN  EX operand A from pipeline register (after alusrc mux)
ex_opb_in  in  XLEN  EX operand B from pipeline register
mem_result  in  XLEN  result currently in MEM
wb_result  in  XLEN  result currently in WB
ex_opa  out  XLEN  forwarded operand A
ex_opb  out  XLEN  forwarded operand B (also branch compare / store data)
fwd_sel_a  out  2  registered select A: 00 none, 01 MEM, 10 WB, 11 WB-hold
fwd_sel_b  out  2  same encoding, operand B
stall  out  1  hold PC and ID, insert bubble into EX

Behaviour:
- Shadow stages, each {valid, rd, we, load}: ex_*, mem_*, wb_*. Every cycle: wb←mem, mem←ex. ex←ID fields if id_valid && !stall && !flush, else bubble (valid=0). Bubbles never match.
- Hold register wb_hold (XLEN): loads wb_result every cycle; supplies operands whose producer retired while the consumer sat in ID.
- Match(s, stage) = use_s && stage.valid && stage.we && stage.rd==s && !(ZERO_REG && s==0).
- Stall (combinational): id_valid && !flush && (Match(rs1,ex) || Match(rs2,ex)) && ex_load. Lasts exactly one cycle per hazard: the next cycle the load is in MEM, which is not a stall condition.
- Select per source s, priority nearest producer first:
  - Match(s,ex) && !ex_load → 01
  - else Match(s,mem) → 10
  - else Match(s,wb) → 11
  - else 00
- fwd_sel_a/b register the selects on the clock edge where ID enters EX. On stall or flush they register 00.
- Load producer one stage ahead is resolved after its stall bubble: it matches mem → 10.
- Operand muxes (combinational from registered selects): 00→ex_*_in, 01→mem_result, 10→wb_result, 11→wb_hold. Zero latency from data inputs to outputs.
- Simultaneous stall and flush: flush wins, stall=0, bubble inserted.
- rs1==rs2 matching the same producer: both selects equal.
- Reset (reset==0 at edge): all shadow valid=0, fwd_sel_a=fwd_sel_b=00, wb_hold=0. Stall reads 0 the cycle after reset. Reset mid-stall cancels the stall. Reset overrides flush.

Optional Feature:
- Macro FWD_HAZARD_STATS_EN.
- Defined: adds outputs stat_stalls[31:0] and stat_fwds[31:0]. stat_stalls increments on each stall cycle; stat_fwds increments by 1 for each nonzero select registered into EX. Counts saturate at 0xFFFFFFFF and clear on reset.
- Undefined: no counters, no ports, identical forwarding/stall timing.

Test Plan:
- ALU chain: add x3 (rd=3) then sub rs1=3 back-to-back → fwd_sel_a=01 in sub's EX cycle; ex_opa=mem_result (e.g. 0x1234), stall stays 0.
- Load-use: load rd=5, next instr rs2=5 → stall=1 for exactly one cycle, bubble in EX; then fwd_sel_b=10, ex_opb=wb_result (0xBEEF).
- Distance-3 producer: write x7, two independent instrs, then rs1=7 → fwd_sel_a=11, ex_opa=wb_hold value captured the prior cycle.
- Zero register: producer rd=0 we=1, consumer rs1=0 → fwd_sel_a=00, ex_opa=ex_opa_in; with ZERO_REG=0 → 01.
- Flush during load-use hazard: flush=1 same cycle as stall condition → stall=0, EX bubble, selects 00 next cycle.
- Reset mid-operation: reset low while stall=1 → next cycle stall=0, both selects 00. With FWD_HAZARD_STATS_EN, counters read 0.

Source files
------------

// File: rtl/forward_hazard_unit.sv
// Operand forwarding and load-use hazard unit with shadow EX/MEM/WB destination tracking.
// Optional event counters are enabled by defining FWD_HAZARD_STATS_EN.
module forward_hazard_unit #(
  parameter int XLEN     = 16,
  parameter int REGW     = 4,
  parameter int ZERO_REG = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic            id_regwrite,
  input  logic            id_is_load,
  input  logic            flush,
  input  logic [XLEN-1:0] ex_opa_in,
  input  logic [XLEN-1:0] ex_opb_in,
  input  logic [XLEN-1:0] mem_result,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] ex_opa,
  output logic [XLEN-1:0] ex_opb,
  output logic [1:0]      fwd_sel_a,
  output logic [1:0]      fwd_sel_b,
  output logic            stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]     stat_stalls,
  output logic [31:0]     stat_fwds
`endif
);

  typedef struct packed {
    logic            valid;
    logic [REGW-1:0] rd;
    logic            we;
    logic            load;
  } stage_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_WB   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  stage_t          r_ex;
  stage_t          r_mem;
  stage_t          r_wb;
  logic [XLEN-1:0] r_wb_hold;
  logic [1:0]      r_sel_a;
  logic [1:0]      r_sel_b;

  logic            w_m1_ex;
  logic            w_m2_ex;
  logic            w_stall;
  logic            w_advance;
  logic [1:0]      w_sel_a;
  logic [1:0]      w_sel_b;
  logic [1:0]      w_sel_a_nx;
  logic [1:0]      w_sel_b_nx;
  stage_t          w_id_stage;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;

  function automatic logic f_match(input logic use_s, input logic [REGW-1:0] s,
                                   input stage_t st);
    logic w_zero;
    w_zero  = (ZERO_REG != 0) && (s == {REGW{1'b0}});
    f_match = use_s && st.valid && st.we && (st.rd == s) && !w_zero;
  endfunction

  // Nearest producer wins; a load still in EX is left to the stall and resolves from MEM.
  function automatic logic [1:0] f_sel(input logic use_s, input logic [REGW-1:0] s,
                                       input stage_t ex_st, input stage_t mem_st,
                                       input stage_t wb_st);
    if (f_match(use_s, s, ex_st) && !ex_st.load) begin
      f_sel = SEL_MEM;
    end else if (f_match(use_s, s, mem_st)) begin
      f_sel = SEL_WB;
    end else if (f_match(use_s, s, wb_st)) begin
      f_sel = SEL_HOLD;
    end else begin
      f_sel = SEL_NONE;
    end
  endfunction

  function automatic logic [XLEN-1:0] f_mux(input logic [1:0] sel, input logic [XLEN-1:0] pipe_v,
                                            input logic [XLEN-1:0] mem_v,
                                            input logic [XLEN-1:0] wb_v,
                                            input logic [XLEN-1:0] hold_v);
    case (sel)
      SEL_NONE: f_mux = pipe_v;
      SEL_MEM:  f_mux = mem_v;
      SEL_WB:   f_mux = wb_v;
      SEL_HOLD: f_mux = hold_v;
      default:  f_mux = pipe_v;
    endcase
  endfunction

  // Hazard detection and select computation for the instruction in ID.
  always_comb begin
    w_m1_ex    = f_match(id_use_rs1, id_rs1, r_ex);
    w_m2_ex    = f_match(id_use_rs2, id_rs2, r_ex);
    w_stall    = id_valid && !flush && (w_m1_ex || w_m2_ex) && r_ex.load;
    w_advance  = id_valid && !w_stall && !flush;
    w_sel_a    = f_sel(id_use_rs1, id_rs1, r_ex, r_mem, r_wb);
    w_sel_b    = f_sel(id_use_rs2, id_rs2, r_ex, r_mem, r_wb);
    w_id_stage = '{valid: 1'b0, rd: {REGW{1'b0}}, we: 1'b0, load: 1'b0};
    if (w_advance) begin
      w_sel_a_nx = w_sel_a;
      w_sel_b_nx = w_sel_b;
      w_id_stage = '{valid: 1'b1, rd: id_rd, we: id_regwrite, load: id_is_load};
    end else begin
      w_sel_a_nx = SEL_NONE;
      w_sel_b_nx = SEL_NONE;
    end
  end

  // Shadow pipeline, retired-result hold register and registered selects.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ex      <= '0;
      r_mem     <= '0;
      r_wb      <= '0;
      r_wb_hold <= {XLEN{1'b0}};
      r_sel_a   <= SEL_NONE;
      r_sel_b   <= SEL_NONE;
    end else begin
      r_wb      <= r_mem;
      r_mem     <= r_ex;
      r_ex      <= w_id_stage;
      r_wb_hold <= wb_result;
      r_sel_a   <= w_sel_a_nx;
      r_sel_b   <= w_sel_b_nx;
    end
  end

  // Operand muxes driven straight from the registered selects.
  always_comb begin
    w_opa = f_mux(r_sel_a, ex_opa_in, mem_result, wb_result, r_wb_hold);
    w_opb = f_mux(r_sel_b, ex_opb_in, mem_result, wb_result, r_wb_hold);
  end

  assign ex_opa    = w_opa;
  assign ex_opb    = w_opb;
  assign fwd_sel_a = r_sel_a;
  assign fwd_sel_b = r_sel_b;
  assign stall     = w_stall;

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] r_stat_stalls;
  logic [31:0] r_stat_fwds;
  logic [1:0]  w_fwd_inc;
  logic [32:0] w_fwd_sum;

  always_comb begin
    w_fwd_inc = {1'b0, |w_sel_a_nx} + {1'b0, |w_sel_b_nx};
    w_fwd_sum = {1'b0, r_stat_fwds} + {31'd0, w_fwd_inc};
  end

  // Saturating event counters.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_stat_stalls <= 32'd0;
      r_stat_fwds   <= 32'd0;
    end else begin
      if (w_stall && (r_stat_stalls != 32'hFFFF_FFFF)) begin
        r_stat_stalls <= r_stat_stalls + 32'd1;
      end else begin
        r_stat_stalls <= r_stat_stalls;
      end
      if (w_fwd_sum[32]) begin
        r_stat_fwds <= 32'hFFFF_FFFF;
      end else begin
        r_stat_fwds <= w_fwd_sum[31:0];
      end
    end
  end

  assign stat_stalls = r_stat_stalls;
  assign stat_fwds   = r_stat_fwds;
`endif

endmodule
